// File: rtl/boss_attack_sequencer_if.sv
// Boss attack sequencer bus: one-cycle control pulses in; slot geometry, phase flags
// and FSM state out.
interface boss_attack_sequencer_if #(
    parameter int NUM_SLOTS = 5
);
    // step and hit are single-cycle pulses with no ready. A step that arrives while an
    // attack is in flight is dropped, not queued. fsm_state: 0 idle, 1 telegraph, 2 fire, 3 defeated.
    logic                     step;
    logic                     hit;
    logic [31:0]              delay;
    logic [NUM_SLOTS-1:0]     slot_valid;
    logic [10*NUM_SLOTS-1:0]  slot_x;
    logic [9*NUM_SLOTS-1:0]   slot_y;
    logic [9:0]               proj_w;
    logic [8:0]               proj_h;
    logic [1:0]               attack_type;
    logic                     telegraph;
    logic                     fire;
    logic [9:0]               boss_hp;
    logic                     enraged;
    logic                     defeated;
    logic [1:0]               fsm_state;

    modport master (
        output step, hit, delay,
        input  slot_valid, slot_x, slot_y, proj_w, proj_h, attack_type,
               telegraph, fire, boss_hp, enraged, defeated, fsm_state
    );

    modport slave (
        input  step, hit, delay,
        output slot_valid, slot_x, slot_y, proj_w, proj_h, attack_type,
               telegraph, fire, boss_hp, enraged, defeated, fsm_state
    );
endinterface

// File: rtl/boss_attack_sequencer.sv
// Boss attack sequencer: walks a 7-pattern attack cycle, telegraphs beams and tracks boss HP.
// Optional feature macro: BOSS_ENRAGE_EN (enrage phase below ENRAGE_HP halves the telegraph).
module boss_attack_sequencer #(
    parameter int NUM_SLOTS = 5,
    parameter int HP_MAX    = 540,
    parameter int HIT_DMG   = 20,
    parameter int ENRAGE_HP = 180,
    parameter int BOSS_X    = 264,
    parameter int BOSS_Y    = 121,
    parameter int BOSS_W    = 400,
    parameter int BOSS_H    = 110,
    parameter int PROJ_W    = 10,
    parameter int PROJ_H    = 15,
    parameter int BEAM_W    = 80,
    parameter int BEAM_H    = 280,
    parameter int DIAG_WH   = 20
) (
    input  logic                   clk_master,
    input  logic                   rst,
    boss_attack_sequencer_if.slave bus
);
`ifdef BOSS_ENRAGE_EN
    localparam bit ENRAGE_ON = 1'b1;
`else
    localparam bit ENRAGE_ON = 1'b0;
`endif
    localparam logic [9:0] HP_MAX_L    = 10'(HP_MAX);
    localparam logic [9:0] HIT_DMG_L   = 10'(HIT_DMG);
    localparam logic [9:0] ENRAGE_HP_L = 10'(ENRAGE_HP);
    localparam logic [8:0] SLOT_Y      = 9'(BOSS_Y + BOSS_H);
    localparam int         XW          = 10 * NUM_SLOTS;
    localparam int         YW          = 9 * NUM_SLOTS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TELEGRAPH = 2'd1,
        S_FIRE      = 2'd2,
        S_DEFEATED  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           pat_q, pat_d;
    logic [31:0]          timer_q, timer_d;
    logic [9:0]           hp_q, hp_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [9:0]           pw_q, pw_d;
    logic [8:0]           ph_q, ph_d;
    logic [1:0]           type_q, type_d;
    logic                 tele_q, tele_d;
    logic                 fire_q, fire_d;

    logic [NUM_SLOTS-1:0] ld_valid;
    logic [XW-1:0]        ld_x;
    logic [YW-1:0]        ld_y;
    logic [9:0]           ld_w;
    logic [8:0]           ld_h;
    logic [1:0]           ld_type;
    logic                 ld_beam;
    logic                 enraged;
    logic [31:0]          dly_raw;
    logic [31:0]          dly_eff;

    function automatic int spread_x(input int i);
        return BOSS_X + (i * BOSS_W) / (NUM_SLOTS - 1) - PROJ_W / 2;
    endfunction

    assign enraged = ENRAGE_ON && (hp_q != 10'd0) && (hp_q <= ENRAGE_HP_L);
    assign dly_raw = enraged ? {1'b0, bus.delay[31:1]} : bus.delay;
    assign dly_eff = (dly_raw == 32'd0) ? 32'd1 : dly_raw;

    // Geometry for the pattern that the next accepted step will launch.
    always_comb begin
        ld_valid = '0;
        ld_x     = '0;
        ld_y     = '0;
        ld_w     = 10'(PROJ_W);
        ld_h     = 9'(PROJ_H);
        ld_type  = 2'b00;
        ld_beam  = 1'b0;
        case (pat_q)
            3'd0, 3'd2: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    ld_valid[i]       = 1'b1;
                    ld_x[10*i +: 10]  = 10'(spread_x(i));
                end
            end
            3'd1, 3'd3: begin
                for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                    ld_valid[i]       = 1'b1;
                    ld_x[10*i +: 10]  = 10'((spread_x(i) + spread_x(i + 1)) / 2);
                end
            end
            3'd4: begin
                ld_valid[1:0] = 2'b11;
                ld_x[9:0]     = 10'(BOSS_X - BEAM_W / 2);
                ld_x[19:10]   = 10'(BOSS_X + BOSS_W - BEAM_W / 2);
                ld_w          = 10'(BEAM_W);
                ld_h          = 9'(BEAM_H);
                ld_type       = 2'b01;
                ld_beam       = 1'b1;
            end
            3'd5: begin
                ld_valid[2:0] = 3'b111;
                ld_x[9:0]     = 10'd144;
                ld_x[19:10]   = 10'd424;
                ld_x[29:20]   = 10'd703;
                ld_w          = 10'(BEAM_W);
                ld_h          = 9'(BEAM_H);
                ld_type       = 2'b01;
                ld_beam       = 1'b1;
            end
            3'd6: begin
                ld_valid[1:0] = 2'b11;
                ld_x[9:0]     = 10'(BOSS_X - DIAG_WH);
                ld_x[19:10]   = 10'(BOSS_X + BOSS_W + DIAG_WH);
                ld_w          = 10'(DIAG_WH);
                ld_h          = 9'(DIAG_WH);
                ld_type       = 2'b10;
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (ld_valid[i]) ld_y[9*i +: 9] = SLOT_Y;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        timer_d = timer_q;
        hp_d    = hp_q;
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        pw_d    = pw_q;
        ph_d    = ph_q;
        type_d  = type_q;
        tele_d  = 1'b0;
        fire_d  = 1'b0;

        if (bus.hit) hp_d = (hp_q > HIT_DMG_L) ? hp_q - HIT_DMG_L : 10'd0;

        // A killing hit wins over everything, including a fire due this same edge.
        if (state_q != S_DEFEATED && hp_d == 10'd0) begin
            state_d = S_DEFEATED;
            timer_d = '0;
            valid_d = '0;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.step) begin
                        valid_d = ld_valid;
                        x_d     = ld_x;
                        y_d     = ld_y;
                        pw_d    = ld_w;
                        ph_d    = ld_h;
                        type_d  = ld_type;
                        pat_d   = (pat_q == 3'd6) ? 3'd0 : pat_q + 3'd1;
                        if (ld_beam) begin
                            state_d = S_TELEGRAPH;
                            tele_d  = 1'b1;
                            timer_d = dly_eff;
                        end else begin
                            state_d = S_FIRE;
                            fire_d  = 1'b1;
                        end
                    end
                end
                S_TELEGRAPH: begin
                    if (timer_q <= 32'd1) begin
                        state_d = S_FIRE;
                        fire_d  = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - 32'd1;
                        tele_d  = 1'b1;
                    end
                end
                S_FIRE:  state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_master) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= 3'd0;
            timer_q <= '0;
            hp_q    <= HP_MAX_L;
            valid_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pw_q    <= '0;
            ph_q    <= '0;
            type_q  <= 2'b00;
            tele_q  <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            timer_q <= timer_d;
            hp_q    <= hp_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pw_q    <= pw_d;
            ph_q    <= ph_d;
            type_q  <= type_d;
            tele_q  <= tele_d;
            fire_q  <= fire_d;
        end
    end

    assign bus.slot_valid  = valid_q;
    assign bus.slot_x      = x_q;
    assign bus.slot_y      = y_q;
    assign bus.proj_w      = pw_q;
    assign bus.proj_h      = ph_q;
    assign bus.attack_type = type_q;
    assign bus.telegraph   = tele_q;
    assign bus.fire        = fire_q;
    assign bus.boss_hp     = hp_q;
    assign bus.enraged     = enraged;
    assign bus.defeated    = (state_q == S_DEFEATED);
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_boss_attack_sequencer.sv
// Bench for boss_attack_sequencer: pattern vector table, hand-written corner sequences,
// and randomized stimulus against a cycle-schedule reference model.
module tb_boss_attack_sequencer;
    logic clk_master = 1'b0;
    logic rst        = 1'b1;

    boss_attack_sequencer_if #(.NUM_SLOTS(5)) bus5 ();
    boss_attack_sequencer_if #(.NUM_SLOTS(3)) bus3 ();

    boss_attack_sequencer #(.NUM_SLOTS(5)) dut (
        .clk_master (clk_master),
        .rst        (rst),
        .bus        (bus5.slave)
    );

    boss_attack_sequencer #(.NUM_SLOTS(3)) dut3 (
        .clk_master (clk_master),
        .rst        (rst),
        .bus        (bus3.slave)
    );

    always #5 clk_master = ~clk_master;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] dly;
        logic [4:0]  valid;
        logic [49:0] x;
        logic [1:0]  typ;
        logic [9:0]  pw;
        logic [8:0]  ph;
        int          tele;
    } vec_t;
    vec_t vecs[8];

    // Reference model: attack schedule expressed as absolute cycle numbers.
    int          m_cyc, m_hp, m_p, m_fire_at, m_tele_from, m_type, m_pw, m_ph;
    bit          m_def;
    int          m_x[5];
    bit          m_v[5];
    logic [49:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not allowed here", name);
    endtask

    task automatic cycle();
        @(posedge clk_master);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    function automatic logic [49:0] px5(input int a, input int b, input int c, input int d, input int e);
        return {10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [44:0] py5(input logic [4:0] v);
        logic [44:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) if (v[i]) r[9*i +: 9] = 9'd231;
        return r;
    endfunction

    function automatic bit exp_enraged(input int hp);
`ifdef BOSS_ENRAGE_EN
        return (hp > 0) && (hp <= 180);
`else
        return (hp < 0);
`endif
    endfunction

    task automatic measure_tele(output int len, output bit fired);
        len   = 0;
        fired = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (bus5.fire) begin
                fired = 1'b1;
                break;
            end
            if (bus5.telegraph) len++;
            cycle();
        end
    endtask

    task automatic advance(input int n);
        int len;
        bit fired;
        for (int j = 0; j < n; j++) begin
            bus5.step = 1'b1;
            cycle();
            bus5.step = 1'b0;
            measure_tele(len, fired);
            check("adv_fire", fired, 1);
            cycle();
        end
    endtask

    task automatic run_vec(input int i);
        int len;
        bit fired;
        bus5.delay = vecs[i].dly;
        bus5.step  = 1'b1;
        cycle();
        bus5.step  = 1'b0;
        measure_tele(len, fired);
        check($sformatf("vec%0d_fire", i), fired, 1);
        check($sformatf("vec%0d_tele_len", i), len, vecs[i].tele);
        check($sformatf("vec%0d_valid", i), bus5.slot_valid, vecs[i].valid);
        check($sformatf("vec%0d_x", i), bus5.slot_x, vecs[i].x);
        check($sformatf("vec%0d_y", i), bus5.slot_y, py5(vecs[i].valid));
        check($sformatf("vec%0d_type", i), bus5.attack_type, vecs[i].typ);
        check($sformatf("vec%0d_size", i), {bus5.proj_w, bus5.proj_h}, {vecs[i].pw, vecs[i].ph});
        cycle();
    endtask

    task automatic model_load(input int p);
        for (int i = 0; i < 5; i++) begin
            m_v[i] = 1'b0;
            m_x[i] = 0;
        end
        m_type = 0; m_pw = 10; m_ph = 15;
        if (p == 0 || p == 2) begin
            for (int i = 0; i < 5; i++) begin
                m_v[i] = 1'b1;
                m_x[i] = 264 + i * 400 / 4 - 5;
            end
        end else if (p == 1 || p == 3) begin
            for (int i = 0; i < 4; i++) begin
                m_v[i] = 1'b1;
                m_x[i] = ((264 + i * 100 - 5) + (264 + (i + 1) * 100 - 5)) / 2;
            end
        end else if (p == 4) begin
            m_v[0] = 1'b1; m_x[0] = 264 - 40;
            m_v[1] = 1'b1; m_x[1] = 664 - 40;
            m_type = 1; m_pw = 80; m_ph = 280;
        end else if (p == 5) begin
            m_v[0] = 1'b1; m_x[0] = 144;
            m_v[1] = 1'b1; m_x[1] = 424;
            m_v[2] = 1'b1; m_x[2] = 703;
            m_type = 1; m_pw = 80; m_ph = 280;
        end else begin
            m_v[0] = 1'b1; m_x[0] = 244;
            m_v[1] = 1'b1; m_x[1] = 684;
            m_type = 2; m_pw = 20; m_ph = 20;
        end
    endtask

    function automatic logic [4:0] m_valid_pk();
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = m_v[i];
        return r;
    endfunction

    function automatic logic [49:0] m_x_pk();
        return px5(m_x[0], m_x[1], m_x[2], m_x[3], m_x[4]);
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit h, input int d);
        int hp_before;
        int dd;
        m_cyc++;
        if (r) begin
            m_hp = 540; m_p = 0; m_def = 1'b0;
            m_fire_at = -100; m_tele_from = -100;
            for (int i = 0; i < 5; i++) begin
                m_v[i] = 1'b0;
                m_x[i] = 0;
            end
            m_type = 0; m_pw = 0; m_ph = 0;
            exp_q.delete();
        end else begin
            hp_before = m_hp;
            if (h) m_hp = (m_hp >= 20) ? m_hp - 20 : 0;
            if (!m_def && m_hp == 0) begin
                m_def = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    m_v[i] = 1'b0;
                    m_x[i] = 0;
                end
                exp_q.delete();
            end else if (!m_def && s && m_cyc > m_fire_at + 1) begin
                dd = exp_enraged(hp_before) ? d / 2 : d;
                if (dd < 1) dd = 1;
                model_load(m_p);
                m_tele_from = m_cyc;
                m_fire_at   = (m_p == 4 || m_p == 5) ? m_cyc + dd : m_cyc;
                exp_q.push_back(m_x_pk());
                m_p = (m_p + 1) % 7;
            end
        end
    endtask

    task automatic compare_all();
        bit e_fire;
        bit e_tele;
        e_fire = !m_def && (m_cyc == m_fire_at);
        e_tele = !m_def && (m_cyc >= m_tele_from) && (m_cyc < m_fire_at);
        check("rand_ctrl", {bus5.fire, bus5.telegraph, bus5.defeated, bus5.enraged, bus5.boss_hp},
              {e_fire, e_tele, m_def, exp_enraged(m_hp), 10'(m_hp)});
        check("rand_slots", {bus5.slot_valid, bus5.slot_x, bus5.slot_y, bus5.attack_type, bus5.proj_w, bus5.proj_h},
              {m_valid_pk(), m_x_pk(), py5(m_valid_pk()), 2'(m_type), 10'(m_pw), 9'(m_ph)});
        if (bus5.fire) begin
            if (exp_q.size() == 0) fail_now("sb_unexpected_fire");
            else check("sb_fire_x", bus5.slot_x, exp_q.pop_front());
        end
    endtask

    initial begin
        int  len, fires, hit_pct, d;
        bit  fired, r, s, h, quiet;

        vecs[0] = '{32'd2, 5'b11111, px5(259, 359, 459, 559, 659), 2'b00, 10'd10, 9'd15, 0};
        vecs[1] = '{32'd2, 5'b01111, px5(309, 409, 509, 609, 0),   2'b00, 10'd10, 9'd15, 0};
        vecs[2] = '{32'd3, 5'b11111, px5(259, 359, 459, 559, 659), 2'b00, 10'd10, 9'd15, 0};
        vecs[3] = '{32'd3, 5'b01111, px5(309, 409, 509, 609, 0),   2'b00, 10'd10, 9'd15, 0};
        vecs[4] = '{32'd4, 5'b00011, px5(224, 624, 0, 0, 0),       2'b01, 10'd80, 9'd280, 4};
        vecs[5] = '{32'd0, 5'b00111, px5(144, 424, 703, 0, 0),     2'b01, 10'd80, 9'd280, 1};
        vecs[6] = '{32'd3, 5'b00011, px5(244, 684, 0, 0, 0),       2'b10, 10'd20, 9'd20, 0};
        vecs[7] = '{32'd1, 5'b11111, px5(259, 359, 459, 559, 659), 2'b00, 10'd10, 9'd15, 0};

        bus5.step = 1'b0; bus5.hit = 1'b0; bus5.delay = 32'd2;
        bus3.step = 1'b0; bus3.hit = 1'b0; bus3.delay = 32'd2;
        m_cyc = 0;

        // Reset values
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_hp", bus5.boss_hp, 540);
        check("rst_flags", {bus5.fire, bus5.telegraph, bus5.enraged, bus5.defeated}, 4'b0000);
        check("rst_slots", {bus5.slot_valid, bus5.slot_x, bus5.slot_y}, 0);
        check("rst_size_type", {bus5.proj_w, bus5.proj_h, bus5.attack_type}, 0);
        check("rst_state", bus5.fsm_state, 0);

        // Three-slot build: spread then offset
        bus3.step = 1'b1;
        cycle();
        bus3.step = 1'b0;
        check("n3_spread_fire", bus3.fire, 1);
        check("n3_spread_valid", bus3.slot_valid, 3'b111);
        check("n3_spread_x", bus3.slot_x, {10'd659, 10'd459, 10'd259});
        check("n3_spread_y", bus3.slot_y, {9'd231, 9'd231, 9'd231});
        cycle();
        bus3.step = 1'b1;
        cycle();
        bus3.step = 1'b0;
        check("n3_offset_valid", bus3.slot_valid, 3'b011);
        check("n3_offset_x", bus3.slot_x, {10'd0, 10'd559, 10'd359});
        check("n3_offset_y", bus3.slot_y, {9'd0, 9'd231, 9'd231});

        // Full pattern cycle including wrap back to p0
        do_reset();
        for (int i = 0; i < 8; i++) run_vec(i);

        // Steps during telegraph are dropped and p advances once
        do_reset();
        advance(4);
        bus5.delay = 32'd6;
        bus5.step  = 1'b1;
        cycle();
        bus5.step  = 1'b0;
        check("drop_tele_on", bus5.telegraph, 1);
        fires = 0;
        for (int k = 0; k < 20; k++) begin
            bus5.step = (k == 1 || k == 3);
            cycle();
            if (bus5.fire) fires++;
        end
        bus5.step = 1'b0;
        check("drop_fire_count", fires, 1);
        bus5.step = 1'b1;
        cycle();
        bus5.step = 1'b0;
        check("drop_next_is_p5", {bus5.slot_valid, bus5.telegraph}, {5'b00111, 1'b1});
        measure_tele(len, fired);
        cycle();

        // Enrage threshold, defeat, steps ignored afterward
        do_reset();
        bus5.hit = 1'b1;
        for (int k = 0; k < 18; k++) cycle();
        bus5.hit = 1'b0;
        check("enr_hp", bus5.boss_hp, 180);
        check("enr_flag", bus5.enraged, exp_enraged(180));
        advance(4);
        bus5.delay = 32'd4;
        bus5.step  = 1'b1;
        cycle();
        bus5.step  = 1'b0;
        measure_tele(len, fired);
        check("enr_fire", fired, 1);
`ifdef BOSS_ENRAGE_EN
        check("enr_tele_len", len, 2);
`else
        check("enr_tele_len", len, 4);
`endif
        cycle();
        bus5.hit = 1'b1;
        for (int k = 0; k < 9; k++) cycle();
        bus5.hit = 1'b0;
        check("dead_hp", bus5.boss_hp, 0);
        check("dead_flags", {bus5.defeated, bus5.enraged, bus5.telegraph, bus5.fire}, 4'b1000);
        check("dead_slots", {bus5.slot_valid, bus5.slot_x, bus5.slot_y}, 0);
        fires = 0;
        for (int k = 0; k < 12; k++) begin
            bus5.step = (k % 3 == 0);
            cycle();
            if (bus5.fire || bus5.telegraph) fires++;
        end
        bus5.step = 1'b0;
        check("dead_ignores_step", fires, 0);
        check("dead_state", bus5.fsm_state, 3);

        // Reset and hit in the same cycle mid-telegraph
        do_reset();
        advance(4);
        bus5.delay = 32'd10;
        bus5.step  = 1'b1;
        cycle();
        bus5.step  = 1'b0;
        cycle();
        cycle();
        check("rsthit_pre_tele", bus5.telegraph, 1);
        bus5.hit = 1'b1;
        rst      = 1'b1;
        cycle();
        bus5.hit = 1'b0;
        rst      = 1'b0;
        check("rsthit_hp", bus5.boss_hp, 540);
        check("rsthit_tele_fire", {bus5.telegraph, bus5.fire}, 2'b00);
        check("rsthit_state", bus5.fsm_state, 0);
        fires = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (bus5.fire) fires++;
        end
        check("rsthit_no_fire", fires, 0);
        bus5.step = 1'b1;
        cycle();
        bus5.step = 1'b0;
        check("rsthit_p_reset", bus5.slot_valid, 5'b11111);
        cycle();

        // Randomized run against the schedule model
        for (int seg = 0; seg < 4; seg++) begin
            hit_pct = (seg == 0) ? 1 : (seg == 1) ? 4 : (seg == 2) ? 8 : 0;
            rst = 1'b1; bus5.step = 1'b0; bus5.hit = 1'b0;
            cycle();
            model_edge(1'b1, 1'b0, 1'b0, 0);
            compare_all();
            for (int c = 0; c < 500; c++) begin
                quiet = (c >= 488);
                r = !quiet && ($urandom_range(0, 299) == 0);
                s = !quiet && ($urandom_range(0, 3) == 0);
                h = !quiet && ($urandom_range(0, 99) < hit_pct);
                d = $urandom_range(0, 5);
                rst = r; bus5.step = s; bus5.hit = h; bus5.delay = 32'(d);
                cycle();
                model_edge(r, s, h, d);
                compare_all();
            end
            rst = 1'b0; bus5.step = 1'b0; bus5.hit = 1'b0;
            check("sb_drained", exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
